// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider controller.
package div_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ITERS = 32;

  localparam logic [XLEN-1:0] DIVZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [XLEN-1:0] neg_if(input logic c, input logic [XLEN-1:0] v);
    return c ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_iter_step.sv
// One restoring shift-subtract step: shift the next dividend bit in, keep the difference if non-negative.
module div_iter_step
  import div_pkg::*;
#(
  parameter int unsigned XLEN = div_pkg::XLEN
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_div,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quo
);

  logic [XLEN:0] w_shifted;
  logic [XLEN:0] w_diff;

  // Partial remainder stays below the divisor, so XLEN+1 bits hold the shifted value.
  always_comb begin
    w_shifted = {i_rem, i_quo[XLEN-1]};
    w_diff    = w_shifted - {1'b0, i_div};
    if (!w_diff[XLEN]) begin
      o_rem = w_diff[XLEN-1:0];
      o_quo = {i_quo[XLEN-2:0], 1'b1};
    end else begin
      o_rem = w_shifted[XLEN-1:0];
      o_quo = {i_quo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// 32-cycle restoring divider controller: operand sign handling, iteration counter and IDLE/BUSY/DONE FSM.
module div_ctrl
  import div_pkg::*;
#(
  parameter int unsigned XLEN  = div_pkg::XLEN,
  parameter int unsigned ITERS = div_pkg::ITERS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_signed,
  input  logic            req_rem,
  input  logic [XLEN-1:0] req_dividend,
  input  logic [XLEN-1:0] req_divisor,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy
);

  localparam int unsigned CNT_W = $clog2(ITERS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_quo;
  logic [XLEN-1:0]  r_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_rem_sel;
  logic             r_divzero;

  logic            w_accept;
  logic [XLEN-1:0] w_dvd_mag;
  logic [XLEN-1:0] w_dvs_mag;
  logic [XLEN-1:0] w_rem_nxt;
  logic [XLEN-1:0] w_quo_nxt;

  assign req_ready  = (r_state == IDLE) & ~flush & reset;
  assign w_accept   = req_valid & req_ready;
  assign resp_valid = (r_state == DONE) & ~flush;
  assign busy       = (r_state != IDLE);

  assign w_dvd_mag = neg_if(req_signed & req_dividend[XLEN-1], req_dividend);
  assign w_dvs_mag = neg_if(req_signed & req_divisor[XLEN-1], req_divisor);

  // Divide-by-zero remainder needs no override: the magnitude re-signed by the dividend sign is the dividend.
  assign resp_data = r_rem_sel ? neg_if(r_neg_r, r_rem)
                   : (r_divzero ? DIVZERO_Q : neg_if(r_neg_q, r_quo));

  div_iter_step #(.XLEN(XLEN)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_div (r_div),
    .o_rem (w_rem_nxt),
    .o_quo (w_quo_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_div     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_rem_sel <= 1'b0;
      r_divzero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state   <= BUSY;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= w_dvd_mag;
            r_div     <= w_dvs_mag;
            r_neg_q   <= req_signed & (req_dividend[XLEN-1] ^ req_divisor[XLEN-1]);
            r_neg_r   <= req_signed & req_dividend[XLEN-1];
            r_rem_sel <= req_rem;
            r_divzero <= (req_divisor == '0);
          end
        end
        BUSY: begin
          if (flush) begin
            r_state <= IDLE;
          end else begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_CNT) r_state <= DONE;
          end
        end
        DONE: begin
          if (flush || resp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameter XLEN, 32, operand and result width; only 32 is supported.
REQ-002 Parameter ITERS, 32, iteration count; fixed equal to XLEN.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low. Ports are named clk and reset.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 reset  in  1  asynchronous active-low reset (asserted at 0).
REQ-006 req_valid  in  1  divide request present.
REQ-007 req_ready  out  1  controller can accept a request.
REQ-008 req_signed  in  1  1 = signed divide, 0 = unsigned.
REQ-009 req_rem  in  1  1 = return remainder, 0 = return quotient.
REQ-010 req_dividend  in  32  dividend (rj).
REQ-011 req_divisor  in  32  divisor (rk).
REQ-012 flush  in  1  pipeline cancel; kills any in-flight operation.
REQ-013 resp_valid  out  1  result available.
REQ-014 resp_ready  in  1  consumer takes the result.
REQ-015 resp_data  out  32  selected quotient or remainder.
REQ-016 busy  out  1  high in BUSY or DONE.

Function
REQ-017 FSM states SHALL be IDLE, BUSY and DONE.
REQ-018 req_ready SHALL equal (state==IDLE) & ~flush & reset.
REQ-019 On req_valid & req_ready at edge E0, the block SHALL latch the operands, req_signed and req_rem, and move to BUSY.
REQ-020 In signed mode the operands SHALL be converted to their magnitudes at acceptance; the original signs SHALL be latched.
REQ-021 BUSY SHALL run exactly 32 restoring shift-subtract iterations, one per cycle, under a 5-bit counter running 0..31.
REQ-022 BUSY SHALL exit to DONE at counter 31; resp_valid SHALL first be high after edge E32 (latency 32 cycles from acceptance).
REQ-023 Quotient sign: the quotient SHALL be negated iff signed mode and the operand signs differ.
REQ-024 Remainder sign: the remainder SHALL be negated iff signed mode and the dividend is negative.
REQ-025 Divisor == 0: quotient SHALL be 0xFFFFFFFF and remainder SHALL be the original dividend, in both modes, with the same 32-cycle latency.
REQ-026 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0 (no trap).
REQ-027 In DONE, resp_valid SHALL be (state==DONE) & ~flush; resp_data SHALL hold stable until the handshake.
REQ-028 On resp_valid & resp_ready the FSM SHALL go DONE->IDLE; at least one IDLE cycle separates operations.
REQ-029 flush in BUSY or DONE SHALL force IDLE at the next edge, with no response; flush has priority over the resp handshake.
REQ-030 flush in IDLE SHALL block acceptance for that cycle.
REQ-031 req_valid while not ready SHALL be ignored; no state change.

Reset
REQ-032 While reset=0: state SHALL be IDLE, counter 0, all datapath registers 0, resp_valid 0, resp_data 0x00000000, busy 0, req_ready 0.
REQ-033 Reset asserted mid-operation SHALL abort immediately (asynchronously) with no response.
REQ-034 req_ready SHALL rise in the first cycle after reset deasserts.

Structure
REQ-035 Package div_pkg SHALL hold the state enum (IDLE/BUSY/DONE), XLEN, ITERS and the constant DIVZERO_Q=0xFFFFFFFF.
REQ-036 The block SHALL contain one sub-module, div_iter_step: combinational single restoring step, taking partial remainder, quotient and divisor and producing next partial remainder and quotient.
REQ-037 Sign handling, the counter and the FSM SHALL reside in div_ctrl.

Verification
REQ-038 Unsigned 100/7, req_rem=0 -> resp_valid 32 cycles after accept, resp_data=14; repeat with req_rem=1 -> 2.
REQ-039 Signed 0xFFFFFFF9/2 (-7/2) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
REQ-040 Unsigned and signed 0x12345678/0 -> quotient 0xFFFFFFFF, remainder 0x12345678.
REQ-041 Signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-042 flush at BUSY counter 10 -> resp_valid never rises; req_ready=1 next cycle; then 9/3 -> 3 after 32 cycles.
REQ-043 resp_ready held low 5 cycles in DONE -> resp_data stable and resp_valid high throughout; reset=0 mid-BUSY -> resp_valid 0, busy 0 immediately.
